// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer placed in front of a synchronous word memory.
// It accepts one request at a time, checks alignment, performs loads with lane
// extraction, and does sub-word stores as read-modify-write. All outputs are
// registered.
module mem_access_unit #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              mem_read_flag,
  output logic              mem_write_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] OP_LDUR   = 3'b000;
  localparam logic [2:0] OP_LDURH  = 3'b001;
  localparam logic [2:0] OP_LDURB  = 3'b010;
  localparam logic [2:0] OP_LDURSH = 3'b011;
  localparam logic [2:0] OP_LDURSB = 3'b100;
  localparam logic [2:0] OP_STUR   = 3'b101;
  localparam logic [2:0] OP_STURH  = 3'b110;
  localparam logic [2:0] OP_STURB  = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_RESP} state_t;

  state_t      r_state;
  logic [2:0]  r_op;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;   // only the low half is needed; full-word stores use req_wdata directly
  logic [2:0]  r_cnt;

  logic        w_misalign;
  logic        w_subword_store;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  // Alignment check on the live request (only consulted in IDLE)
  always_comb begin
    w_misalign = 1'b0;
    case (req_op)
      OP_LDUR, OP_STUR:              w_misalign = (req_addr[1:0] != 2'b00);
      OP_LDURH, OP_LDURSH, OP_STURH: w_misalign = req_addr[0];
      default:                       w_misalign = 1'b0;
    endcase
  end

  assign w_subword_store = (r_op == OP_STURH) || (r_op == OP_STURB);

  // Lane extraction and sign/zero extension of the returned memory word
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_lane)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_op)
      OP_LDURH:  w_load_data = {16'h0000, w_half};
      OP_LDURB:  w_load_data = {24'h000000, w_byte};
      OP_LDURSH: w_load_data = {{16{w_half[15]}}, w_half};
      OP_LDURSB: w_load_data = {{24{w_byte[7]}}, w_byte};
      default:   w_load_data = mem_rdata;
    endcase
  end

  // Read-modify-write merge: splice the store lane into the word just read
  always_comb begin
    w_merge_data = mem_rdata;
    if (r_op == OP_STURH) begin
      if (r_lane[1]) w_merge_data[31:16] = r_wdata;
      else           w_merge_data[15:0]  = r_wdata;
    end else begin
      case (r_lane)
        2'd0: w_merge_data[7:0]   = r_wdata[7:0];
        2'd1: w_merge_data[15:8]  = r_wdata[7:0];
        2'd2: w_merge_data[23:16] = r_wdata[7:0];
        2'd3: w_merge_data[31:24] = r_wdata[7:0];
        default: w_merge_data = mem_rdata;
      endcase
    end
  end

  // Sequencer FSM; memory flags rise on entry to RD/WR, resp_valid one cycle after entry to RESP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_op           <= OP_LDUR;
      r_lane         <= 2'd0;
      r_wdata        <= 16'h0000;
      r_cnt          <= 3'd0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_data      <= 32'h0;
      resp_err       <= 1'b0;
      mem_read_flag  <= 1'b0;
      mem_write_flag <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op      <= req_op;
            r_lane    <= req_addr[1:0];
            r_wdata   <= req_wdata[15:0];
            req_ready <= 1'b0;
            resp_data <= 32'h0;
            resp_err  <= 1'b0;
            if (w_misalign) begin
              resp_err <= 1'b1;
              r_state  <= S_RESP;
            end else if (req_op == OP_STUR) begin
              mem_addr       <= req_addr[ADDR_W+1:2];
              mem_wdata      <= req_wdata;
              mem_write_flag <= 1'b1;
              r_state        <= S_WR;
            end else begin
              mem_addr      <= req_addr[ADDR_W+1:2];
              mem_read_flag <= 1'b1;
              r_state       <= S_RD;
            end
          end
        end
        S_RD: begin
          mem_read_flag <= 1'b0;
          r_cnt         <= 3'(MEM_LAT - 1);
          r_state       <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            if (w_subword_store) begin
              mem_wdata      <= w_merge_data;
              mem_write_flag <= 1'b1;
              r_state        <= S_WR;
            end else begin
              resp_data <= w_load_data;
              r_state   <= S_RESP;
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_WR: begin
          mem_write_flag <= 1'b0;
          r_state        <= S_RESP;
        end
        S_RESP: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
